// File: rtl/adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_capture
// Purpose  : Detects clk_AD rising edges on mclk, latches ADC samples, and runs an
//            arm/trigger FSM that captures one frame into a FIFO for readout.
//            Optional macro ADC_CAPTURE_DECIM_EN adds the decim input.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_capture #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 512
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              clk_AD,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              rd_en,
`ifdef ADC_CAPTURE_DECIM_EN
  input  logic [3:0]        decim,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int              C_DEPTH    = 1 << ADDR_W;
  localparam int              C_CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [C_CNT_W-1:0] C_FRAME = C_CNT_W'(FRAME_LEN);
  localparam logic [ADDR_W:0] C_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                sample_stb, use_stb;
  logic                smp_vld_q;
  logic [DATA_W-1:0]   cur_q, prev_q;
  logic [C_CNT_W-1:0]  scnt_q, scnt_d, scnt_inc;
  logic                have_prev_q, have_prev_d;
  logic                trig_hit, wr_req, flush;
  logic                push, pop, drop;
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                empty_q, full_q, overflow_q, rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [C_DEPTH];

  // clk_AD is asynchronous: two flops to settle, a third for edge detection.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= clk_AD;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign sample_stb = sync2_q & ~sync3_q;

`ifdef ADC_CAPTURE_DECIM_EN
  logic [3:0] decim_q, dcnt_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= 4'd0;
      dcnt_q  <= 4'd0;
    end else if (flush) begin
      decim_q <= decim;
      dcnt_q  <= 4'd0;
    end else if (sample_stb) begin
      dcnt_q  <= (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;
    end
  end

  assign use_stb = sample_stb & (dcnt_q == 4'd0);
`else
  assign use_stb = sample_stb;
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q     <= '0;
      prev_q    <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      smp_vld_q <= use_stb;
      if (use_stb) begin
        prev_q <= cur_q;
        cur_q  <= adc_data;
      end
    end
  end

  assign trig_hit = have_prev_q & (prev_q < trig_level) & (cur_q >= trig_level);
  assign scnt_inc = scnt_q + C_CNT_W'(1);

  // Samples are acted on the cycle after the strobe, once cur_q holds them.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    have_prev_d = have_prev_q;
    wr_req      = 1'b0;
    flush       = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d     = S_ARMED;
            flush       = 1'b1;
            scnt_d      = '0;
            have_prev_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (smp_vld_q) begin
            if (!trig_en || trig_hit) begin
              wr_req  = 1'b1;
              scnt_d  = C_CNT_W'(1);
              state_d = (FRAME_LEN == 1) ? S_DONE : S_CAPTURE;
            end else begin
              have_prev_d = 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (smp_vld_q) begin
            wr_req = 1'b1;
            scnt_d = scnt_inc;
            if (scnt_inc == C_FRAME) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      scnt_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      have_prev_q <= have_prev_d;
    end
  end

  // A pop frees the slot the same cycle, so push into a full FIFO is legal then.
  assign pop  = rd_en & ~empty_q & ~flush;
  assign push = wr_req & (~full_q | pop);
  assign drop = wr_req & full_q & ~pop;

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + (ADDR_W+1)'(1);
    else if (pop && !push)  count_d = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == C_FULL_CNT);
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
      if (flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (push) mem_q[wr_ptr_q] <= cur_q;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE) & ~abort;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_capture
// Purpose  : Self-checking bench for adc_sample_capture with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_capture;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int FRAME_LEN = 12;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              mclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_AD = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              trig_en = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, empty, full, busy, frame_done, overflow;

  adc_sample_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
    .mclk(mclk), .rst_n(rst_n), .clk_AD(clk_AD), .adc_data(adc_data),
    .arm(arm), .abort(abort), .trig_en(trig_en), .trig_level(trig_level),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 mclk = ~mclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting for first sample/trigger, 2 capturing, 3 frame complete
  int                m_mode = 0;
  int                m_nsmp = 0;
  bit                m_have_prev = 0;
  bit                m_ovf = 0;
  bit                m_pend = 0;
  logic [DATA_W-1:0] m_cur = '0, m_prev = '0;
  logic              h1 = 0, h2 = 0, h3 = 0;
  logic [DATA_W-1:0] m_fifo [$];
  bit                e_rd_valid = 0;
  logic [DATA_W-1:0] e_rd_data = '0;

  task automatic model_reset();
    m_mode = 0; m_nsmp = 0; m_have_prev = 0; m_ovf = 0; m_pend = 0;
    m_cur = '0; m_prev = '0; h1 = 0; h2 = 0; h3 = 0;
    m_fifo.delete();
    e_rd_valid = 0;
  endtask

  task automatic model_step();
    bit flush, popd, wr, stb;
    logic [DATA_W-1:0] pv;
    flush = (m_mode == 0) && arm && !abort;
    popd = 0; wr = 0; pv = '0;
    if (rd_en && m_fifo.size() > 0 && !flush) begin
      pv = m_fifo.pop_front();
      popd = 1;
    end
    if (abort) m_mode = 0;
    else begin
      case (m_mode)
        0: if (arm) begin
             m_fifo.delete(); m_ovf = 0; m_have_prev = 0; m_nsmp = 0; m_mode = 1;
           end
        1: if (m_pend) begin
             if (!trig_en || (m_have_prev && m_prev < trig_level && m_cur >= trig_level)) begin
               wr = 1; m_nsmp = 1; m_mode = (FRAME_LEN == 1) ? 3 : 2;
             end else m_have_prev = 1;
           end
        2: if (m_pend) begin
             wr = 1; m_nsmp++;
             if (m_nsmp == FRAME_LEN) m_mode = 3;
           end
        default: m_mode = 0;
      endcase
    end
    if (wr) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(m_cur);
      else m_ovf = 1;
    end
    e_rd_valid = popd;
    if (popd) e_rd_data = pv;
    // A clk_AD rise seen at edge n-2 (after a low at n-3) is a strobe at edge n.
    stb = h2 && !h3;
    if (stb) begin
      m_prev = m_cur;
      m_cur  = adc_data;
    end
    m_pend = stb;
    h3 = h2; h2 = h1; h1 = clk_AD;
  endtask

  initial begin
    forever begin
      @(posedge mclk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  logic [DATA_W-1:0] got [$];
  int                fd_cnt = 0;

  initial begin
    forever begin
      @(negedge mclk);
      chk("busy",       int'(busy),       int'(m_mode != 0));
      chk("empty",      int'(empty),      int'(m_fifo.size() == 0));
      chk("full",       int'(full),       int'(m_fifo.size() == DEPTH));
      chk("overflow",   int'(overflow),   int'(m_ovf));
      chk("frame_done", int'(frame_done), int'(m_mode == 3 && !abort));
      chk("rd_valid",   int'(rd_valid),   int'(e_rd_valid));
      if (e_rd_valid) chk("rd_data", int'(rd_data), int'(e_rd_data));
      if (rd_valid) got.push_back(rd_data);
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic ad_sample(input logic [DATA_W-1:0] v, input int hi, input int lo);
    clk_AD = 1'b1; adc_data = v;
    cyc(hi);
    clk_AD = 1'b0;
    cyc(lo);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cyc(1); arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; cyc(1); abort = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    rd_en = 1'b1;
    while (!empty && guard < 4 * DEPTH) begin
      cyc(1);
      guard++;
    end
    rd_en = 1'b0;
    cyc(2);
    chk("drain_bound", int'(empty), 1);
  endtask

  logic [DATA_W-1:0] exp_s [$];
  logic [DATA_W-1:0] v9;
  int                fd0;
  bit                a_done;

  initial begin
    @(posedge mclk); #1;
    // reset with clk_AD toggling
    for (int i = 0; i < 5; i++) begin
      clk_AD = ~clk_AD; cyc(1);
    end
    chk("rst_empty", int'(empty), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1; clk_AD = 1'b0;
    cyc(4);
    chk("idle_empty", int'(empty), 1);

    // free-running capture of a ramp with concurrent reads
    trig_en = 1'b0; got.delete(); fd0 = fd_cnt;
    pulse_arm();
    rd_en = 1'b1;
    for (int v = 0; v < 16; v++) ad_sample(8'(v), 3, 3);
    cyc(4); rd_en = 1'b0; cyc(2);
    chk("ramp_count", got.size(), FRAME_LEN);
    for (int i = 0; i < got.size() && i < FRAME_LEN; i++) chk("ramp_val", int'(got[i]), i);
    chk("ramp_fd", fd_cnt - fd0, 1);

    // level trigger with crossing
    trig_en = 1'b1; trig_level = 8'h80; got.delete();
    pulse_arm();
    ad_sample(8'h10, 3, 3); ad_sample(8'h70, 3, 3);
    ad_sample(8'h90, 3, 3); ad_sample(8'hA0, 3, 3);
    cyc(4);
    chk("trig_busy", int'(busy), 1);
    pulse_abort();
    chk("trig_abort", int'(busy), 0);
    drain();
    chk("trig_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("trig_first", int'(got[0]), 'h90);
      chk("trig_second", int'(got[1]), 'hA0);
    end

    // no crossing: stays armed
    pulse_arm();
    ad_sample(8'h90, 3, 3); ad_sample(8'h95, 3, 3); ad_sample(8'h98, 3, 3);
    cyc(4);
    chk("nocross_busy", int'(busy), 1);
    chk("nocross_empty", int'(empty), 1);
    pulse_abort();

    // overflow: full frame without reads
    trig_en = 1'b0; got.delete(); exp_s.delete(); fd0 = fd_cnt;
    pulse_arm();
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_s.push_back(8'($urandom));
      ad_sample(exp_s[i], 3, 3);
    end
    cyc(4);
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_fd", fd_cnt - fd0, 1);
    chk("ovf_busy", int'(busy), 0);
    drain();
    chk("ovf_count", got.size(), DEPTH);
    for (int i = 0; i < got.size() && i < DEPTH; i++) chk("ovf_val", int'(got[i]), int'(exp_s[i]));
    pulse_arm();
    chk("rearm_ovf", int'(overflow), 0);
    chk("rearm_empty", int'(empty), 1);
    pulse_abort();

    // abort after three samples
    got.delete(); fd0 = fd_cnt;
    pulse_arm();
    ad_sample(8'h11, 3, 3); ad_sample(8'h22, 3, 3); ad_sample(8'h33, 3, 3);
    cyc(4);
    pulse_abort();
    chk("abort_busy", int'(busy), 0);
    chk("abort_fd", fd_cnt - fd0, 0);
    drain();
    chk("abort_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("abort_v0", int'(got[0]), 'h11);
      chk("abort_v2", int'(got[2]), 'h33);
    end

    // arm and abort together: abort wins
    arm = 1'b1; abort = 1'b1; cyc(1); arm = 1'b0; abort = 1'b0;
    chk("armabort_busy", int'(busy), 0);
    ad_sample(8'h44, 3, 3); cyc(2);
    chk("armabort_empty", int'(empty), 1);

    // simultaneous push and pop while full
    got.delete(); exp_s.delete();
    pulse_arm();
    for (int i = 0; i < DEPTH; i++) begin
      exp_s.push_back(8'($urandom));
      ad_sample(exp_s[i], 3, 3);
    end
    cyc(2);
    chk("pp_full_before", int'(full), 1);
    v9 = 8'($urandom);
    clk_AD = 1'b1; adc_data = v9;
    cyc(3);
    rd_en = 1'b1; clk_AD = 1'b0;
    cyc(1);
    rd_en = 1'b0;
    cyc(3);
    chk("pp_full_after", int'(full), 1);
    chk("pp_no_ovf", int'(overflow), 0);
    pulse_abort();
    exp_s.push_back(v9);
    drain();
    chk("pp_count", got.size(), DEPTH + 1);
    for (int i = 0; i < got.size() && i < DEPTH + 1; i++) chk("pp_order", int'(got[i]), int'(exp_s[i]));

    // randomized traffic, including one asynchronous reset mid-run
    a_done = 0;
    fork
      begin
        repeat (150) ad_sample(8'($urandom), $urandom_range(3, 6), $urandom_range(3, 6));
        a_done = 1;
      end
      begin
        int n;
        n = 0;
        while (!a_done) begin
          arm   = ($urandom_range(0, 29) == 0);
          abort = ($urandom_range(0, 199) == 0);
          rd_en = ($urandom_range(0, 2) == 0);
          if (arm) begin
            trig_en    = 1'($urandom);
            trig_level = 8'($urandom);
          end
          n++;
          if (n == 400) begin
            #2 rst_n = 1'b0;
            cyc(2);
            rst_n = 1'b1;
          end else begin
            cyc(1);
          end
        end
        arm = 1'b0; abort = 1'b0; rd_en = 1'b0;
      end
    join
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
